// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier between two requesters.
// Optional WAIT timeout abort enabled by defining MUL_SHARE_ARBITER_TIMEOUT_EN.
module mul_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req_b0,
    input  logic [N-1:0]     req_q0,
    input  logic [N-1:0]     req_b1,
    input  logic [N-1:0]     req_q1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*N-1:0]   rsp_data,
    output logic             rsp_err,
    output logic             mul_start,
    output logic [N-1:0]     mul_b,
    output logic [N-1:0]     mul_q,
    output logic             mul_rst,
    input  logic [2*N-1:0]   mul_a,
    input  logic             mul_done
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e state;
    logic   ptr;
    logic   first_wait;
    logic   grant;
    logic   accept;

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] wait_cnt;
    logic            abort_q;
    logic            err_q;

    assign rsp_err = err_q;
    assign mul_rst = rst | abort_q;
`else
    assign rsp_err = 1'b0;
    assign mul_rst = rst;
`endif

    // Pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ptr : req_valid[1];
        req_ready = 2'b00;
        if (state == StIdle && !rst && req_valid != 2'b00) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            ptr        <= 1'b0;
            first_wait <= 1'b0;
            mul_start  <= 1'b0;
            mul_b      <= '0;
            mul_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
            wait_cnt   <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
            abort_q   <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        mul_b     <= grant ? req_b1 : req_b0;
                        mul_q     <= grant ? req_q1 : req_q0;
                        rsp_id    <= grant;
                        mul_start <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    first_wait <= 1'b1;
                    state      <= StWait;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                StWait: begin
                    first_wait <= 1'b0;
                    // A done still high from the previous operation lands in the first WAIT cycle.
                    if (!first_wait && mul_done) begin
                        rsp_data  <= mul_a;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
                        abort_q   <= 1'b1;
                        rsp_data  <= '0;
                        err_q     <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a small bench-side multiplier model.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_b0, req_q0, req_b1, req_q1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;
    logic       mul_start, mul_rst, mul_done;
    logic [3:0] mul_b, mul_q;
    logic [7:0] mul_a;

    logic       auto_mul;
    logic       man_done;
    logic [7:0] man_a;
    logic       m_done;
    logic [7:0] m_a, m_b, m_q;
    int         m_cnt;

    int total  = 0;
    int passed = 0;

    mul_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_b0    (req_b0),
        .req_q0    (req_q0),
        .req_b1    (req_b1),
        .req_q1    (req_q1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_b     (mul_b),
        .mul_q     (mul_q),
        .mul_rst   (mul_rst),
        .mul_a     (mul_a),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    assign mul_done = auto_mul ? m_done : man_done;
    assign mul_a    = auto_mul ? m_a : man_a;

    // Multiplier stand-in: done one cycle, four edges after start is seen.
    always @(posedge clk or posedge mul_rst) begin
        if (mul_rst) begin
            m_cnt <= 0; m_done <= 1'b0; m_a <= '0; m_b <= '0; m_q <= '0;
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) m_a <= m_b * m_q;
            if (mul_start) begin
                m_cnt <= 3; m_b <= {4'b0, mul_b}; m_q <= {4'b0, mul_q};
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic wait_rsp(input int budget, output int starts, output bit ok);
        starts = 0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
            if (mul_start) starts++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0; auto_mul = 1'b1; man_done = 1'b0; man_a = '0;
        req_b0 = 4'd1; req_q0 = 4'd2; req_b1 = 4'd3; req_q1 = 4'd4;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready);
        else passed++;
        total++;
        if ({rsp_valid, rsp_id, rsp_err, mul_start} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_id, rsp_err, mul_start});
        else passed++;
        total++;
        if ({mul_b, mul_q, rsp_data} !== 16'h0000)
            $display("FAIL reset_data: got %h want 0000", {mul_b, mul_q, rsp_data});
        else passed++;
        total++;
        if (mul_rst !== 1'b1) $display("FAIL reset_mul_rst_hi: got %b want 1", mul_rst);
        else passed++;
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
        total++;
        if (mul_rst !== 1'b0) $display("FAIL reset_mul_rst_lo: got %b want 0", mul_rst);
        else passed++;
    endtask

    task automatic test_single();
        int starts; bit ok; bit stable;
        @(negedge clk);
        req_b0 = 4'd3; req_q0 = 4'd5; req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready);
        else passed++;
        @(negedge clk);
        req_valid = 2'b00; req_b0 = 4'hf; req_q0 = 4'hf;
        total++;
        if ({mul_start, mul_b, mul_q} !== {1'b1, 4'd3, 4'd5})
            $display("FAIL single_launch: got %h want 135", {mul_start, mul_b, mul_q});
        else passed++;
        stable = 1'b1; starts = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
            if (mul_start) starts++;
            if (mul_b !== 4'd3 || mul_q !== 4'd5) stable = 1'b0;
        end
        total++;
        if ({ok, stable, starts} !== {2'b11, 32'd0})
            $display("FAIL single_wait: got ok=%b stable=%b starts=%0d want 1 1 0", ok, stable, starts);
        else passed++;
        total++;
        if ({rsp_data, rsp_id, rsp_err} !== {8'd15, 1'b0, 1'b0})
            $display("FAIL single_rsp: got data=%0d id=%b err=%b want 15 0 0", rsp_data, rsp_id, rsp_err);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b want 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_contention();
        int starts; bit ok; logic g; logic [7:0] want;
        @(negedge clk);
        rst = 1'b1;
        req_b0 = 4'd9; req_q0 = 4'd9; req_b1 = 4'd15; req_q1 = 4'd15;
        req_valid = 2'b11; rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            want = g ? 8'd225 : 8'd81;
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (req_ready != 2'b00) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            total++;
            if ({ok, req_ready} !== {1'b1, g ? 2'b10 : 2'b01})
                $display("FAIL contention_grant%0d: got ok=%b ready=%b want grant %b", k, ok, req_ready, g);
            else passed++;
            wait_rsp(20, starts, ok);
            total++;
            if ({ok, rsp_id, rsp_data} !== {1'b1, g, want})
                $display("FAIL contention_rsp%0d: got ok=%b id=%b data=%0d want id=%b data=%0d",
                         k, ok, rsp_id, rsp_data, g, want);
            else passed++;
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int starts; bit ok;
        @(negedge clk);
        req_b1 = 4'd7; req_q1 = 4'd6; req_valid = 2'b10; rsp_ready = 1'b0;
        @(negedge clk);
        req_b0 = 4'd2; req_q0 = 4'd2; req_valid = 2'b01;
        wait_rsp(20, starts, ok);
        total++;
        if (ok !== 1'b1) $display("FAIL bp_rsp_seen: got %b want 1", ok);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_data, rsp_id, req_ready, mul_start} !== {1'b1, 8'd42, 1'b1, 2'b00, 1'b0})
                $display("FAIL bp_hold%0d: got v=%b d=%0d id=%b rdy=%b st=%b want 1 42 1 00 0",
                         i, rsp_valid, rsp_data, rsp_id, req_ready, mul_start);
            else passed++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 3'b001)
            $display("FAIL bp_release: got v=%b rdy=%b want 0 01", rsp_valid, req_ready);
        else passed++;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(20, starts, ok);
        total++;
        if ({ok, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'd4})
            $display("FAIL bp_next: got ok=%b id=%b data=%0d want 1 0 4", ok, rsp_id, rsp_data);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_stale_done();
        @(negedge clk);
        auto_mul = 1'b0; man_done = 1'b1; man_a = 8'hee;
        req_b0 = 4'd2; req_q0 = 4'd3; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        total++;
        if (mul_start !== 1'b1) $display("FAIL stale_launch: got %b want 1", mul_start);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL stale_masked: got %b want 0", rsp_valid);
        else passed++;
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL stale_still_waiting: got %b want 0", rsp_valid);
        else passed++;
        man_a = 8'd6; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        total++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'd6, 1'b0})
            $display("FAIL stale_capture: got v=%b d=%0d id=%b want 1 6 0", rsp_valid, rsp_data, rsp_id);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int starts; bit ok;
        @(negedge clk);
        auto_mul = 1'b0; man_done = 1'b0;
        req_b1 = 4'd5; req_q1 = 4'd5; req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_b0 = 4'd4; req_q0 = 4'd4; req_valid = 2'b11;
        #1;
        total++;
        if ({rsp_valid, mul_rst, req_ready, mul_start} !== 5'b01000)
            $display("FAIL midrst_state: got v=%b mrst=%b rdy=%b st=%b want 0 1 00 0",
                     rsp_valid, mul_rst, req_ready, mul_start);
        else passed++;
        @(negedge clk);
        rst = 1'b0; auto_mul = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL midrst_ptr: got %b want 01", req_ready);
        else passed++;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(20, starts, ok);
        total++;
        if ({ok, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 8'd16, 1'b0})
            $display("FAIL midrst_fresh: got ok=%b id=%b data=%0d err=%b want 1 0 16 0",
                     ok, rsp_id, rsp_data, rsp_err);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit early;
        @(negedge clk);
        auto_mul = 1'b0; man_done = 1'b0;
        req_b0 = 4'd3; req_q0 = 4'd3; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        early = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (mul_rst || rsp_valid) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) $display("FAIL timeout_early: got %b want 0", early);
        else passed++;
        @(negedge clk);
        total++;
        if ({mul_rst, rsp_valid, rsp_err, rsp_data} !== {3'b111, 8'd0})
            $display("FAIL timeout_abort: got mrst=%b v=%b err=%b d=%0d want 1 1 1 0",
                     mul_rst, rsp_valid, rsp_err, rsp_data);
        else passed++;
        @(negedge clk);
        total++;
        if ({mul_rst, rsp_valid, rsp_err} !== 3'b011)
            $display("FAIL timeout_pulse_width: got mrst=%b v=%b err=%b want 0 1 1",
                     mul_rst, rsp_valid, rsp_err);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        auto_mul = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stale_done();
        test_reset_mid_wait();
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one shift-add multiplier (`start`/`B`/`Q` in, `A`/`done` out) between two requesters. It accepts operand pairs over per-requester valid/ready handshakes, launches the multiplier and holds its operands stable for the whole operation. It returns the 2N-bit product tagged with the requester ID. It sits between the client logic and the `multiplier` instance and is the only block allowed to drive the multiplier's `start`, `B`, `Q` and `rst`.

## Interface
- `N`, 4, operand width; product width is 2N (8 at default, matching the multiplier's `A`)
- `TIMEOUT`, 31, max cycles in WAIT before abort (used only with the macro; 5-bit counter at default)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  2  per-requester operand valid
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req_b0`, `req_q0`  in  N each  requester 0 operands
- `req_b1`, `req_q1`  in  N each  requester 1 operands
- `rsp_valid`  out  1  product available
- `rsp_ready`  in  1  consumer accepts product
- `rsp_id`  out  1  requester the product belongs to
- `rsp_data`  out  2N  product B*Q
- `rsp_err`  out  1  product invalid (timeout abort)
- `mul_start`  out  1  to multiplier `start`
- `mul_b`, `mul_q`  out  N each  to multiplier `B`, `Q`; registered
- `mul_rst`  out  1  to multiplier `rst`
- `mul_a`  in  2N  from multiplier `A`
- `mul_done`  in  1  from multiplier `done`

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. Reset: IDLE, priority pointer = 0, all outputs 0 (`mul_rst` follows `rst`).
- IDLE: the grant goes to the requester with `req_valid`. If both are valid, the requester equal to the pointer wins. `req_ready[g]` = 1 combinationally for the granted one only.
- Accept (`req_valid[g] & req_ready[g]` at an edge): latch operands into `mul_b`/`mul_q`, latch `g` into `rsp_id`, go to LAUNCH.
- LAUNCH: `mul_start` = 1 for exactly one cycle, then WAIT.
- WAIT: ignore `mul_done` in the first WAIT cycle (stale-done mask). Afterwards, `mul_done` = 1 captures `mul_a` into `rsp_data`, clears `rsp_err` and moves to RESP.
- RESP: `rsp_valid` = 1. `rsp_id`, `rsp_data` and `rsp_err` are held until `rsp_ready` = 1. On that edge: return to IDLE and set the pointer to `~rsp_id`.
- `mul_b`/`mul_q` are constant from LAUNCH through the end of WAIT. `req_ready` = 0 outside IDLE.
- Requester operands are ignored unless accepted. Dropping `req_valid` before acceptance is legal.
- A requester that stays valid is granted at most every other transaction while the other is also valid (no starvation).
- `rst` mid-operation: the state machine returns to IDLE immediately. Any in-flight product is discarded and `mul_rst` is asserted.

## Timing
- Accept edge T: LAUNCH at T+1 (`mul_start` high), WAIT from T+2.
- `mul_done` sampled at edge D ≥ T+3: `rsp_valid` high from D+1.
- `rsp_valid & rsp_ready` at edge R: IDLE at R+1. The next accept is possible at edge R+1, so there is one idle cycle between transactions.
- End-to-end latency = multiplier latency + 3 cycles + response backpressure.
- `mul_rst` = `rst` OR the internal abort pulse. The abort pulse is registered and one cycle wide.

## Configuration
- `MUL_SHARE_ARBITER_TIMEOUT_EN` defined: a WAIT-cycle counter runs.
  - When the counter reaches `TIMEOUT` with no accepted `mul_done`, the block pulses `mul_rst` for one cycle and sets `rsp_data` = 0 and `rsp_err` = 1.
  - The block then goes to RESP. The response is delivered normally with `rsp_err` = 1.
  - The counter clears on LAUNCH.
- Not defined: no counter. WAIT waits indefinitely, `rsp_err` is tied to 0 and `mul_rst` = `rst`.

## Test plan
- Single request: req0 B=3, Q=5 → one `mul_start` pulse, `mul_b`/`mul_q` stable through WAIT, `rsp_valid` with `rsp_data`=15 and `rsp_id`=0.
- Contention: both requesters valid continuously (r0 9×9, r1 15×15) → grants alternate 0,1,0,…; products 81 and 225 with correct IDs.
- Backpressure: `rsp_ready` held low for 10 cycles → `rsp_valid`/`rsp_data`/`rsp_id` held; `req_ready` = 0 throughout; no second `mul_start`.
- Stale done: `mul_done` held high from the previous op into the first WAIT cycle → ignored; the product is captured only on the later `done`.
- Reset mid-WAIT: `rst` asserted → IDLE, `rsp_valid`=0, `mul_rst`=1 and pointer=0 while `rst` is high; a fresh request after release completes correctly.
- Timeout (macro on, `TIMEOUT`=31): `mul_done` never asserted → `mul_rst` pulse 31 cycles after WAIT entry, then `rsp_valid` with `rsp_err`=1 and `rsp_data`=0.
